axi_burst_memory: RTL and testbench
===================================

AXI_BURST_MEMORY -- requirements
Module: axi_burst_memory

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, meaning AXI address width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 128, meaning data bus width; legal values are 32, 64, 128 and 256.
REQ-003 SHALL have parameter DEPTH, default 1024, meaning number of DATA_WIDTH-bit memory words.
REQ-004 SHALL have parameter RD_LATENCY, default 1, meaning cycles from AR acceptance to the first rvalid; legal range 1-15.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have the AR channel ports arvalid (in, 1), arready (out, 1), araddr (in, ADDR_WIDTH), arlen (in, 8), arsize (in, 3) and arburst (in, 2).
REQ-008 SHALL have the R channel ports rvalid (out, 1), rdata (out, DATA_WIDTH), rresp (out, 2), rlast (out, 1) and rready (in, 1).
REQ-009 SHALL have the AW channel ports awvalid (in, 1), awready (out, 1), awaddr (in, ADDR_WIDTH), awlen (in, 8), awsize (in, 3) and awburst (in, 2).
REQ-010 SHALL have the W channel ports wvalid (in, 1), wdata (in, DATA_WIDTH), wstrb (in, DATA_WIDTH/8), wlast (in, 1) and wready (out, 1).
REQ-011 SHALL have the B channel ports bvalid (out, 1), bresp (out, 2) and bready (in, 1).

Function
REQ-012 SHALL run the read and write paths as independent FSMs, each with one outstanding burst and no ID or reordering support.
REQ-013 Read FSM SHALL use states R_IDLE -> R_LAT -> R_DATA -> R_IDLE.
- arready=1 only in R_IDLE; AR handshake moves to R_LAT.
- R_LAT counts RD_LATENCY-1 cycles; with RD_LATENCY=1, rvalid asserts the cycle after AR acceptance.
REQ-014 In R_DATA, rvalid SHALL stay 1 and rdata/rresp/rlast SHALL stay stable until rready=1; the next beat presents the cycle after each handshake (full throughput, one beat per cycle).
REQ-015 rlast SHALL be 1 on beat arlen (zero-based); its handshake returns the read FSM to R_IDLE.
REQ-016 Write FSM SHALL use states W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
- awready=1 only in W_IDLE.
- wready=1 only in W_DATA.
- bvalid=1 only in W_RESP; the B handshake returns to W_IDLE.
REQ-017 Each accepted W beat SHALL update only the bytes whose wstrb bit is 1; wstrb=0 leaves the word unchanged.
REQ-018 Word index SHALL equal address >> log2(DATA_WIDTH/8); the low address bits SHALL be ignored.
REQ-019 Burst address sequencing SHALL be:
- FIXED (0): constant index.
- INCR (1): index+1 per beat.
- WRAP (2): index+1 per beat, wrapping within the (len+1)-word block aligned to (len+1) words.
REQ-020 A burst SHALL receive SLVERR (2'b10) on every R beat, or in bresp, with no memory write performed for the burst, when any of these holds:
- size != log2(DATA_WIDTH/8);
- burst = 3;
- WRAP with len not in {1, 3, 7, 15};
- the start index is >= DEPTH.
REQ-021 Any individual beat whose index is >= DEPTH SHALL return rresp=SLVERR with rdata=0, or have its write suppressed with the final bresp=SLVERR; in-range beats of the same burst complete normally with OKAY (2'b00).
REQ-022 If wlast=1 before beat awlen, or wlast=0 on beat awlen, the write FSM SHALL still consume exactly awlen+1 beats and return bresp=SLVERR; beats already written remain written.
REQ-023 When a read beat and a write beat target the same word in the same cycle, the read SHALL return the pre-write data.
REQ-024 The AR and AW handshakes SHALL be accepted in the same cycle when both FSMs are idle.
REQ-025 rdata SHALL be 0 whenever rvalid=0.

Reset
REQ-026 While rstn=0, the following SHALL be 0 asynchronously, and both FSMs SHALL be idle: arready, awready, rvalid, rlast, rresp, rdata, wready, bvalid and bresp.
REQ-027 Reset asserted mid-burst SHALL abandon the burst with no response issued; memory contents SHALL NOT be cleared by reset.
REQ-028 arready and awready SHALL first assert in the cycle after rstn deasserts.

Verification
REQ-029 INCR write then read: AW addr 0x100, len 3, size 4, W data 0xA0..0xA3 with wstrb all-ones -> bresp OKAY; AR of the same burst returns 0xA0..0xA3 with rlast on the 4th beat and rresp OKAY.
REQ-030 Strobe and backpressure: write 0x00 to word 5, then write 0xFF.. with wstrb=0x0001; read with rready toggling 1/0 -> read returns 0x..00FF, and rdata stays stable while rready=0.
REQ-031 WRAP: with words 8-11 preloaded with 8..11, AR addr word 10, len 3, burst WRAP -> reads 10, 11, 8, 9.
REQ-032 Errors:
- AR with start index DEPTH -> 1 beat, rresp SLVERR, rdata 0.
- AW with size 3 -> bresp SLVERR and memory unchanged.
- Early wlast on beat 1 of len 3 -> bresp SLVERR after 4 beats.
REQ-033 Latency and reset: with RD_LATENCY=4, the first rvalid arrives 4 cycles after the AR handshake; rstn pulled low mid-read -> rvalid drops the same cycle, and a later read returns the data written before reset.

Source files
------------

// File: rtl/axi_burst_memory.sv
// AXI4 burst memory: independent read and write FSMs, one outstanding burst each,
// no IDs. Byte-strobed writes, FIXED/INCR/WRAP sequencing, SLVERR on illegal or
// out-of-range accesses. Memory contents survive reset.
module axi_burst_memory #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 1024,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  output logic                    rvalid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  input  logic                    rready,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    wvalid,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  output logic                    wready,
  output logic                    bvalid,
  output logic [1:0]              bresp,
  input  logic                    bready
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int SZ = $clog2(NB);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_LAT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Whole-burst error: wrong size, reserved burst type, bad wrap length, start off the end.
  function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [7:0] len, input logic [ADDR_WIDTH-1:0] start);
    logic bad_wrap;
    bad_wrap = (burst == 2'd2) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    return (size != 3'(SZ)) || (burst == 2'd3) || bad_wrap || (start >= DEPTH_A);
  endfunction

  // Word index of the following beat; WRAP keeps the upper bits and wraps the low len bits.
  function automatic logic [ADDR_WIDTH-1:0] next_idx(input logic [ADDR_WIDTH-1:0] idx,
                                                     input logic [7:0] len, input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] mask;
    mask = ADDR_WIDTH'(len);
    case (burst)
      2'd0:    return idx;
      2'd2:    return (idx & ~mask) | ((idx + ONE_A) & mask);
      default: return idx + ONE_A;
    endcase
  endfunction

  // ---------------- read path ----------------
  r_state_t              r_state;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [7:0]            r_len, r_cnt;
  logic [1:0]            r_burst;
  logic                  r_err;
  logic [3:0]            lat_cnt;
  logic [ADDR_WIDTH-1:0] ar_start, ld_idx;
  logic                  ar_err, ld_bad, ld_last;
  logic [DATA_WIDTH-1:0] ld_data;

  assign ar_start = araddr >> SZ;
  assign ar_err   = burst_err(arsize, arburst, arlen, ar_start);

  // Beat about to be presented: first beat from AR (or the held start), later beats from the sequencer.
  always_comb begin
    ld_idx  = next_idx(r_idx, r_len, r_burst);
    ld_bad  = r_err;
    ld_last = (r_cnt + 8'd1 == r_len);
    if (r_state == R_IDLE) begin
      ld_idx  = ar_start;
      ld_bad  = ar_err;
      ld_last = (arlen == 8'd0);
    end else if (r_state == R_LAT) begin
      ld_idx  = r_idx;
      ld_last = (r_len == 8'd0);
    end
    ld_bad  = ld_bad || (ld_idx >= DEPTH_A);
    ld_data = ld_bad ? '0 : mem[ld_idx[IW-1:0]];
  end

  // Read FSM: accept AR, wait out the latency, then stream beats held stable until rready.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= OKAY;
      rlast   <= 1'b0;
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_burst <= '0;
      r_err   <= 1'b0;
      lat_cnt <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid && arready) begin
            arready <= 1'b0;
            r_idx   <= ar_start;
            r_len   <= arlen;
            r_burst <= arburst;
            r_err   <= ar_err;
            r_cnt   <= '0;
            if (RD_LATENCY <= 1) begin
              r_state <= R_DATA;
              rvalid  <= 1'b1;
              rdata   <= ld_data;
              rresp   <= ld_bad ? SLVERR : OKAY;
              rlast   <= ld_last;
            end else begin
              r_state <= R_LAT;
              lat_cnt <= 4'(RD_LATENCY - 2);
            end
          end else begin
            arready <= 1'b1;
          end
        end
        R_LAT: begin
          if (lat_cnt == 4'd0) begin
            r_state <= R_DATA;
            rvalid  <= 1'b1;
            rdata   <= ld_data;
            rresp   <= ld_bad ? SLVERR : OKAY;
            rlast   <= ld_last;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast) begin
              r_state <= R_IDLE;
              rvalid  <= 1'b0;
              rdata   <= '0;
              rresp   <= OKAY;
              rlast   <= 1'b0;
              arready <= 1'b1;
            end else begin
              r_idx <= ld_idx;
              r_cnt <= r_cnt + 8'd1;
              rdata <= ld_data;
              rresp <= ld_bad ? SLVERR : OKAY;
              rlast <= ld_last;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---------------- write path ----------------
  w_state_t              w_state;
  logic [ADDR_WIDTH-1:0] w_idx, aw_start;
  logic [7:0]            w_len, w_cnt;
  logic [1:0]            w_burst;
  logic                  w_err, w_slv, aw_err;
  logic                  w_beat, w_beat_bad, w_we;

  assign aw_start   = awaddr >> SZ;
  assign aw_err     = burst_err(awsize, awburst, awlen, aw_start);
  assign w_beat     = (w_state == W_DATA) && wvalid && wready;
  assign w_beat_bad = (w_idx >= DEPTH_A) || (wlast != (w_cnt == w_len));
  assign w_we       = w_beat && !w_err && (w_idx < DEPTH_A);

  // Byte-masked store; storage is intentionally outside reset so contents survive it.
  always_ff @(posedge clk) begin
    if (w_we)
      for (int b = 0; b < NB; b++)
        if (wstrb[b]) mem[w_idx[IW-1:0]][8*b +: 8] <= wdata[8*b +: 8];
  end

  // Write FSM: accept AW, consume exactly len+1 beats, then hold the response until bready.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= OKAY;
      w_idx   <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
      w_slv   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid && awready) begin
            awready <= 1'b0;
            wready  <= 1'b1;
            w_state <= W_DATA;
            w_idx   <= aw_start;
            w_len   <= awlen;
            w_burst <= awburst;
            w_cnt   <= '0;
            w_err   <= aw_err;
            w_slv   <= aw_err;
          end else begin
            awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_beat) begin
            if (w_cnt == w_len) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bresp   <= (w_slv || w_beat_bad) ? SLVERR : OKAY;
              w_state <= W_RESP;
            end else begin
              w_cnt <= w_cnt + 8'd1;
              w_idx <= next_idx(w_idx, w_len, w_burst);
              w_slv <= w_slv || w_beat_bad;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            bresp   <= OKAY;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_burst_memory.sv
// Directed + randomized bench for axi_burst_memory against a word-array reference model.
module tb_axi_burst_memory;
  localparam int AW = 32, DW = 128, DEPTH = 64, LAT = 4;

  logic clk = 1'b0, rstn = 1'b0;
  logic arvalid = 0, arready;
  logic [AW-1:0] araddr = '0;
  logic [7:0] arlen = '0;
  logic [2:0] arsize = '0;
  logic [1:0] arburst = '0;
  logic rvalid, rlast, rready = 0;
  logic [DW-1:0] rdata;
  logic [1:0] rresp;
  logic awvalid = 0, awready;
  logic [AW-1:0] awaddr = '0;
  logic [7:0] awlen = '0;
  logic [2:0] awsize = '0;
  logic [1:0] awburst = '0;
  logic wvalid = 0, wlast = 0, wready;
  logic [DW-1:0] wdata = '0;
  logic [DW/8-1:0] wstrb = '0;
  logic bvalid, bready = 0;
  logic [1:0] bresp;

  axi_burst_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RD_LATENCY(LAT)) dut (
    .clk(clk), .rstn(rstn),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rready(rready),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [DW-1:0] mdl [DEPTH];
  logic [DW-1:0] wbuf [16];
  logic [15:0]   sbuf [16];
  logic [DW-1:0] rbuf [16];
  logic [1:0]    rrbuf [16];
  logic          rlbuf [16];

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference sequencing straight from the burst definitions.
  function automatic int beat_idx(input int start, input int len, input int burst, input int i);
    int n, base;
    n = len + 1;
    if (burst == 0) return start;
    if (burst == 2) begin
      base = (start / n) * n;
      return base + (start - base + i) % n;
    end
    return start + i;
  endfunction

  function automatic bit legal(input int size, input int burst, input int len, input int start);
    if (size != 4 || burst == 3) return 0;
    if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 0;
    return start < DEPTH;
  endfunction

  task automatic axi_write(input int addr, input int len, input int size, input int burst,
                           input int early, output logic [1:0] resp);
    int t;
    @(negedge clk);
    awaddr = AW'(addr); awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst); awvalid = 1;
    t = 0;
    while (!awready && t < 50) begin @(negedge clk); t++; end
    chk("aw_ready", awready, 1);
    @(negedge clk);
    awvalid = 0;
    for (int i = 0; i <= len; i++) begin
      if ($urandom_range(3) == 0) begin wvalid = 0; @(negedge clk); end
      chk("bvalid_early", bvalid, 0);
      wdata = wbuf[i]; wstrb = sbuf[i];
      wlast = (early >= 0) ? (i == early) : (i == len);
      wvalid = 1;
      t = 0;
      while (!wready && t < 50) begin @(negedge clk); t++; end
      chk("w_ready", wready, 1);
      @(negedge clk);
    end
    wvalid = 0; wlast = 0;
    chk("wready_off", wready, 0);
    bready = 1;
    t = 0;
    while (!bvalid && t < 50) begin @(negedge clk); t++; end
    chk("b_valid", bvalid, 1);
    resp = bresp;
    @(negedge clk);
    bready = 0;
    chk("b_done", {bvalid, awready}, 2'b01);
  endtask

  // Collects beats into rbuf/rrbuf/rlbuf; checks idle rdata and stability while stalled.
  task automatic axi_read(input int addr, input int len, input int size, input int burst,
                          input bit toggle, input bit abort, output int nb, output int lat);
    int t, g;
    bit done, held_v;
    logic [159:0] held;
    nb = 0; held = '0;
    @(negedge clk);
    araddr = AW'(addr); arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst); arvalid = 1;
    t = 0;
    while (!arready && t < 50) begin @(negedge clk); t++; end
    chk("ar_ready", arready, 1);
    @(negedge clk);
    arvalid = 0; lat = 1;
    while (!rvalid && lat < 60) begin
      chk("rdata_idle", rdata, 0);
      @(negedge clk); lat++;
    end
    if (abort) return;
    done = 0; held_v = 0; g = 0;
    while (!done && g < 300) begin
      if (!rvalid) begin chk("rvalid_hold", rvalid, 1); break; end
      if (held_v) chk("r_stable", {rdata, rresp, rlast}, held);
      rready = toggle ? (g % 2 == 1) : ($urandom_range(2) != 0);
      if (rready) begin
        rbuf[nb] = rdata; rrbuf[nb] = rresp; rlbuf[nb] = rlast;
        nb++; done = rlast || nb >= 16; held_v = 0;
      end else begin
        held = {rdata, rresp, rlast}; held_v = 1;
      end
      @(negedge clk); g++;
    end
    rready = 0;
    chk("rvalid_end", {rvalid, rdata}, 0);
  endtask

  task automatic write_chk(input string tag, input int addr, input int len, input int size,
                           input int burst, input int early);
    logic [1:0] resp, exp;
    int idx, start;
    bit ok;
    start = addr >> 4;
    ok = legal(size, burst, len, start);
    exp = ok ? 2'b00 : 2'b10;
    if (early >= 0 && early != len) exp = 2'b10;
    axi_write(addr, len, size, burst, early, resp);
    for (int i = 0; i <= len; i++) begin
      idx = beat_idx(start, len, burst, i);
      if (idx >= DEPTH) exp = 2'b10;
      else if (ok)
        for (int b = 0; b < 16; b++) if (sbuf[i][b]) mdl[idx][8*b +: 8] = wbuf[i][8*b +: 8];
    end
    chk({tag, "_bresp"}, resp, exp);
  endtask

  task automatic read_chk(input string tag, input int addr, input int len, input int size,
                          input int burst, input bit toggle);
    int nb, lat, idx, start;
    bit ok;
    logic [DW-1:0] ed;
    logic [1:0] er;
    start = addr >> 4;
    ok = legal(size, burst, len, start);
    axi_read(addr, len, size, burst, toggle, 0, nb, lat);
    chk({tag, "_lat"}, lat, LAT);
    chk({tag, "_beats"}, nb, len + 1);
    for (int i = 0; i <= len && i < nb; i++) begin
      idx = beat_idx(start, len, burst, i);
      if (!ok || idx >= DEPTH) begin ed = '0; er = 2'b10; end
      else begin ed = mdl[idx]; er = 2'b00; end
      chk({tag, "_data"}, rbuf[i], ed);
      chk({tag, "_resp"}, rrbuf[i], er);
      chk({tag, "_last"}, rlbuf[i], (i == len));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, lat, len, burst, size, start;
    logic [DW-1:0] oldv, newv;
    logic [1:0] resp;

    // Reset state and first ready
    repeat (2) @(negedge clk);
    chk("reset_outs", {arready, awready, rvalid, rlast, rresp, rdata, wready, bvalid, bresp}, 0);
    rstn = 1;
    #1 chk("ready_pre", {arready, awready}, 2'b00);
    @(negedge clk);
    chk("ready_post", {arready, awready}, 2'b11);

    // Fill the whole memory so every word is known to the model
    for (int k = 0; k < DEPTH / 16; k++) begin
      for (int i = 0; i < 16; i++) begin
        wbuf[i] = {$urandom, $urandom, $urandom, $urandom}; sbuf[i] = 16'hFFFF;
      end
      write_chk("fill", k * 256, 15, 4, 1, -1);
    end

    // INCR write then read of 0xA0..0xA3
    for (int i = 0; i < 4; i++) begin wbuf[i] = 128'hA0 + 128'(i); sbuf[i] = 16'hFFFF; end
    write_chk("incr", 'h100, 3, 4, 1, -1);
    read_chk("incr", 'h100, 3, 4, 1, 0);
    for (int i = 0; i < 4; i++) chk("incr_const", rbuf[i], 128'hA0 + 128'(i));

    // Strobe + rready backpressure
    wbuf[0] = '0; sbuf[0] = 16'hFFFF;
    write_chk("w5_zero", 5 * 16, 0, 4, 1, -1);
    wbuf[0] = '1; sbuf[0] = 16'h0001;
    write_chk("w5_strb", 5 * 16, 0, 4, 1, -1);
    read_chk("w5", 5 * 16, 0, 4, 1, 1);
    chk("w5_const", rbuf[0], 128'hFF);

    // WRAP read from word 10 of block 8..11
    for (int i = 0; i < 4; i++) begin wbuf[i] = 128'(8 + i); sbuf[i] = 16'hFFFF; end
    write_chk("wrap_pre", 8 * 16, 3, 4, 1, -1);
    read_chk("wrap", 10 * 16, 3, 4, 2, 1);
    chk("wrap_seq", {rbuf[0][7:0], rbuf[1][7:0], rbuf[2][7:0], rbuf[3][7:0]}, 32'h0A0B0809);

    // Errors
    read_chk("ar_oob", DEPTH * 16, 0, 4, 1, 0);
    chk("ar_oob_const", {rrbuf[0], rbuf[0]}, {2'b10, 128'h0});
    wbuf[0] = {4{32'h5A5A_1234}}; sbuf[0] = 16'hFFFF;
    write_chk("bad_size", 20 * 16, 0, 3, 1, -1);
    read_chk("bad_size", 20 * 16, 0, 4, 1, 0);
    for (int i = 0; i < 4; i++) begin wbuf[i] = {$urandom, $urandom, $urandom, $urandom}; sbuf[i] = 16'hFFFF; end
    axi_write(40 * 16, 3, 4, 1, 1, resp);
    chk("early_wlast_bresp", resp, 2'b10);
    for (int i = 0; i < 4; i++) mdl[40 + i] = wbuf[i];
    read_chk("early_wlast", 40 * 16, 3, 4, 1, 0);
    for (int i = 0; i < 4; i++) begin wbuf[i] = {$urandom, $urandom, $urandom, $urandom}; sbuf[i] = 16'hFFFF; end
    write_chk("tail_oob", (DEPTH - 2) * 16, 3, 4, 1, -1);
    read_chk("tail_oob", (DEPTH - 2) * 16, 3, 4, 1, 0);

    // Simultaneous AR/AW; write beat lands on the same edge the read samples the word
    oldv = mdl[30];
    newv = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    araddr = 30 * 16; arlen = 0; arsize = 4; arburst = 1; arvalid = 1;
    awaddr = 30 * 16; awlen = 0; awsize = 4; awburst = 1; awvalid = 1;
    chk("both_ready", {arready, awready}, 2'b11);
    @(negedge clk); arvalid = 0; awvalid = 0;
    @(negedge clk);
    @(negedge clk);
    wdata = newv; wstrb = 16'hFFFF; wlast = 1; wvalid = 1;
    chk("coll_wready", wready, 1);
    @(negedge clk); wvalid = 0; wlast = 0;
    chk("coll_rvalid", rvalid, 1);
    chk("coll_old", rdata, oldv);
    rready = 1;
    @(negedge clk); rready = 0;
    chk("coll_bvalid", {bvalid, bresp}, 3'b100);
    bready = 1;
    @(negedge clk); bready = 0;
    mdl[30] = newv;
    read_chk("coll_new", 30 * 16, 0, 4, 1, 0);

    // Randomized write/read traffic
    for (int it = 0; it < 24; it++) begin
      burst = ($urandom_range(7) == 0) ? 3 : int'($urandom_range(2));
      size  = ($urandom_range(7) == 0) ? 3 : 4;
      if (burst == 2) len = (2 << $urandom_range(3)) - 1;
      else len = int'($urandom_range(7));
      start = int'($urandom_range(DEPTH + 2));
      for (int i = 0; i <= len; i++) begin
        wbuf[i] = {$urandom, $urandom, $urandom, $urandom}; sbuf[i] = 16'($urandom);
      end
      write_chk("rnd_w", start * 16 + int'($urandom_range(15)), len, size, burst, -1);
      read_chk("rnd_r", start * 16, len, 4, (burst == 3) ? 1 : burst, 0);
    end

    // Reset mid-read: burst abandoned, memory retained
    axi_read(0, 7, 4, 1, 0, 1, nb, lat);
    chk("abort_lat", lat, LAT);
    rstn = 0;
    #1 chk("rst_async", {rvalid, rdata, arready, awready}, 0);
    @(negedge clk); rstn = 1;
    @(negedge clk);
    chk("rst_ready", {arready, awready}, 2'b11);
    read_chk("post_rst", 0, 7, 4, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
